// File: rtl/dram_timing_ctrl.sv
`timescale 1ns/1ps
// dram_timing_ctrl: per-command timing interval tracker, power-up init timer
// and optional auto-refresh request generator for a DRAM command FSM.
// Optional feature macro: DRAM_AUTO_REFRESH_EN (refresh interval counting,
// rf_req and rf_overflow). Without it, rf_req and rf_overflow are tied low.

package dram_pack;
  typedef enum logic [2:0] {
    CMD_IDLE      = 3'd0,
    CMD_INIT      = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_READ      = 3'd3,
    CMD_WRITE     = 3'd4,
    CMD_PRECHARGE = 3'd5,
    CMD_REFRESH   = 3'd6,
    CMD_MRS       = 3'd7
  } cmd_fsm_t;
endpackage

module dram_timing_ctrl
  import dram_pack::*;
#(
  parameter logic [15:0] tINIT = 16'd200,
  parameter logic [15:0] tRCD  = 16'd4,
  parameter logic [15:0] tRD   = 16'd8,
  parameter logic [15:0] tWR   = 16'd8,
  parameter logic [15:0] tRP   = 16'd4,
  parameter logic [15:0] tRFC  = 16'd32,
  parameter logic [15:0] tREFI = 16'd1560
) (
  input  logic     CLK,
  input  logic     RST,
  input  cmd_fsm_t cmd_state,
  input  logic     init_req,
  output logic     init_done,
  output logic     tACT_done,
  output logic     tRD_done,
  output logic     tWR_done,
  output logic     tPRE_done,
  output logic     tREF_done,
  output logic     rf_req,
  output logic     rf_overflow
);

  cmd_fsm_t    r_prev_state;
  logic [15:0] r_tcnt;
  logic        r_init_req_d;
  logic        r_init_busy;
  logic [15:0] r_init_cnt;
  logic        r_init_done;

  logic        w_timed;
  logic [15:0] w_tparam;
  logic        w_entry;
  logic        w_expired;
  logic        w_init_start;

  // Map the current command state to its timing parameter; zero marks untimed states.
  always_comb begin
    w_timed  = 1'b0;
    w_tparam = 16'd0;
    case (cmd_state)
      CMD_ACTIVATE: begin
        w_timed  = 1'b1;
        w_tparam = tRCD;
      end
      CMD_READ: begin
        w_timed  = 1'b1;
        w_tparam = tRD;
      end
      CMD_WRITE: begin
        w_timed  = 1'b1;
        w_tparam = tWR;
      end
      CMD_PRECHARGE: begin
        w_timed  = 1'b1;
        w_tparam = tRP;
      end
      CMD_REFRESH: begin
        w_timed  = 1'b1;
        w_tparam = tRFC;
      end
      default: begin
        w_timed  = 1'b0;
        w_tparam = 16'd0;
      end
    endcase
  end

  // An entry is the first cycle of a timed state, including a direct switch between timed states.
  assign w_entry = w_timed && (cmd_state != r_prev_state);

  // The interval is over once the counter has drained and the state has not just changed.
  assign w_expired = !RST && w_timed && !w_entry && (r_tcnt == 16'd0);

  assign tACT_done = w_expired && (cmd_state == CMD_ACTIVATE);
  assign tRD_done  = w_expired && (cmd_state == CMD_READ);
  assign tWR_done  = w_expired && (cmd_state == CMD_WRITE);
  assign tPRE_done = w_expired && (cmd_state == CMD_PRECHARGE);
  assign tREF_done = w_expired && (cmd_state == CMD_REFRESH);

  // Remember the previous command state and run the saturating interval down-counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev_state <= CMD_IDLE;
      r_tcnt       <= 16'd0;
    end else begin
      r_prev_state <= cmd_state;
      if (w_entry) begin
        r_tcnt <= w_tparam - 16'd1;
      end else if (r_tcnt != 16'd0) begin
        r_tcnt <= r_tcnt - 16'd1;
      end
    end
  end

  // A new init interval starts only on a rising request while neither running nor complete.
  assign w_init_start = init_req && !r_init_req_d && !r_init_busy && !r_init_done;

  // Power-up init timer; init_done is sticky until reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_init_req_d <= 1'b0;
      r_init_busy  <= 1'b0;
      r_init_cnt   <= 16'd0;
      r_init_done  <= 1'b0;
    end else begin
      r_init_req_d <= init_req;
      if (w_init_start) begin
        if (tINIT == 16'd1) begin
          r_init_done <= 1'b1;
        end else begin
          r_init_busy <= 1'b1;
          r_init_cnt  <= tINIT - 16'd1;
        end
      end else if (r_init_busy) begin
        if (r_init_cnt == 16'd1) begin
          r_init_done <= 1'b1;
          r_init_busy <= 1'b0;
          r_init_cnt  <= 16'd0;
        end else begin
          r_init_cnt <= r_init_cnt - 16'd1;
        end
      end
    end
  end

  assign init_done = r_init_done;

`ifdef DRAM_AUTO_REFRESH_EN
  logic [15:0] r_refi_cnt;
  logic        r_rf_req;
  logic        r_rf_ovf;
  logic        w_ref_entry;
  logic        w_refi_wrap;

  assign w_ref_entry = w_entry && (cmd_state == CMD_REFRESH);
  assign w_refi_wrap = r_init_done && (r_refi_cnt == (tREFI - 16'd1));

  // Refresh interval counter: the cycle init completes, or a REFRESH entry cycle, counts as 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_refi_cnt <= 16'd0;
      r_rf_req   <= 1'b0;
      r_rf_ovf   <= 1'b0;
    end else begin
      if (w_ref_entry) begin
        r_rf_req <= 1'b0;
        if (r_init_done) begin
          r_refi_cnt <= (tREFI == 16'd1) ? 16'd0 : 16'd1;
        end
      end else if (r_init_done) begin
        if (w_refi_wrap) begin
          r_refi_cnt <= 16'd0;
          r_rf_req   <= 1'b1;
          if (r_rf_req) begin
            r_rf_ovf <= 1'b1;
          end
        end else begin
          r_refi_cnt <= r_refi_cnt + 16'd1;
        end
      end
    end
  end

  assign rf_req      = r_rf_req;
  assign rf_overflow = r_rf_ovf;
`else
  logic w_unused_refi;
  assign w_unused_refi = ^tREFI;
  assign rf_req        = 1'b0;
  assign rf_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_dram_timing_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for dram_timing_ctrl: directed timing scenarios,
// randomized command sequences and an interval-arithmetic reference model.

module tb_dram_timing_ctrl;
  import dram_pack::*;

  localparam logic [15:0] P_INIT = 16'd200;
  localparam logic [15:0] P_RCD  = 16'd4;
  localparam logic [15:0] P_RD   = 16'd8;
  localparam logic [15:0] P_WR   = 16'd8;
  localparam logic [15:0] P_RP   = 16'd4;
  localparam logic [15:0] P_RFC  = 16'd32;
  localparam logic [15:0] P_REFI = 16'd1560;

  logic     CLK;
  logic     RST;
  cmd_fsm_t cmd_state;
  logic     init_req;
  logic     init_done;
  logic     tACT_done;
  logic     tRD_done;
  logic     tWR_done;
  logic     tPRE_done;
  logic     tREF_done;
  logic     rf_req;
  logic     rf_overflow;

  int total = 0;
  int bad   = 0;

  int       cyc;
  cmd_fsm_t mPrev;
  int       mEntry;
  bit       mReqPrev;
  bit       mInitActive;
  int       mInitStart;
  bit       mRfReq;
  bit       mRfOvf;
  bit       mAnchorValid;
  int       mAnchor;

  dram_timing_ctrl #(
    .tINIT(P_INIT), .tRCD(P_RCD), .tRD(P_RD), .tWR(P_WR),
    .tRP(P_RP), .tRFC(P_RFC), .tREFI(P_REFI)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cmd_state(cmd_state),
    .init_req(init_req),
    .init_done(init_done),
    .tACT_done(tACT_done),
    .tRD_done(tRD_done),
    .tWR_done(tWR_done),
    .tPRE_done(tPRE_done),
    .tREF_done(tREF_done),
    .rf_req(rf_req),
    .rf_overflow(rf_overflow)
  );

  // Free-running 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int periodOf(cmd_fsm_t s);
    case (s)
      CMD_ACTIVATE:  return int'(P_RCD);
      CMD_READ:      return int'(P_RD);
      CMD_WRITE:     return int'(P_WR);
      CMD_PRECHARGE: return int'(P_RP);
      CMD_REFRESH:   return int'(P_RFC);
      default:       return 0;
    endcase
  endfunction

  function automatic bit expInitDone();
    return mInitActive && (cyc >= mInitStart + int'(P_INIT));
  endfunction

  task automatic modelReset();
    mPrev        = CMD_IDLE;
    mEntry       = 0;
    mReqPrev     = 1'b0;
    mInitActive  = 1'b0;
    mInitStart   = 0;
    mRfReq       = 1'b0;
    mRfOvf       = 1'b0;
    mAnchorValid = 1'b0;
    mAnchor      = 0;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expv;
    logic [7:0] actv;
    int         t;
    bit         expired;
    t       = periodOf(cmd_state);
    expired = (t != 0) && (cmd_state == mPrev) && ((cyc - mEntry) >= t);
    expv = {expInitDone(),
            expired && (cmd_state == CMD_ACTIVATE),
            expired && (cmd_state == CMD_READ),
            expired && (cmd_state == CMD_WRITE),
            expired && (cmd_state == CMD_PRECHARGE),
            expired && (cmd_state == CMD_REFRESH),
            mRfReq, mRfOvf};
    actv = {init_done, tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req, rf_overflow};
    total++;
    assert (actv === expv) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d state=%s observed=%b expected=%b (init,act,rd,wr,pre,ref,rfreq,rfovf)",
             tag, cyc, cmd_state.name(), actv, expv);
    end
  endtask

  task automatic modelAdvance();
    bit entry;
    bit initNow;
    entry   = (periodOf(cmd_state) != 0) && (cmd_state != mPrev);
    initNow = expInitDone();
    if (cmd_state != mPrev) mEntry = cyc;
    mPrev = cmd_state;
    if (init_req && !mReqPrev && !mInitActive) begin
      mInitActive = 1'b1;
      mInitStart  = cyc;
    end
    mReqPrev = init_req;
`ifdef DRAM_AUTO_REFRESH_EN
    if (entry && (cmd_state == CMD_REFRESH)) begin
      mRfReq = 1'b0;
      if (initNow) begin
        mAnchor      = cyc;
        mAnchorValid = 1'b1;
      end
    end else if (initNow) begin
      if (!mAnchorValid) begin
        mAnchor      = cyc;
        mAnchorValid = 1'b1;
      end
      if (((cyc - mAnchor) % int'(P_REFI)) == int'(P_REFI) - 1) begin
        if (mRfReq) mRfOvf = 1'b1;
        mRfReq = 1'b1;
      end
    end
`else
    if (entry && initNow) mAnchor = cyc;
`endif
    cyc++;
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then advance the model on the edge.
  task automatic applyStimulus(input cmd_fsm_t c, input logic req, input string tag);
    cmd_state = c;
    init_req  = req;
    @(negedge CLK);
    checkOutput(tag);
    @(posedge CLK);
    modelAdvance();
    #1;
  endtask

  task automatic holdState(input cmd_fsm_t c, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(c, 1'b0, tag);
  endtask

  task automatic checkAllLow(input string tag);
    logic [7:0] actv;
    actv = {init_done, tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req, rf_overflow};
    total++;
    assert (actv === 8'b0) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=00000000", tag, actv);
    end
  endtask

  // Directed scenarios followed by randomized command traffic.
  initial begin
    RST       = 1'b1;
    cmd_state = CMD_IDLE;
    init_req  = 1'b0;
    cyc       = 0;
    modelReset();
    repeat (3) @(posedge CLK);
    #1;
    checkAllLow("reset_state");
    RST = 1'b0;

    // Init pulse at cycle 0, ACTIVATE at cycle 10, direct switch to READ at cycle 16.
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i < 10) ? CMD_IDLE : (i < 16) ? CMD_ACTIVATE : CMD_READ, (i == 0), "act_read");
    end

    // WRITE abandoned after 3 cycles, then re-entered.
    holdState(CMD_WRITE, 3, "write_abandon");
    holdState(CMD_IDLE, 1, "write_gap");
    holdState(CMD_WRITE, 12, "write_reentry");

    // Run through init completion, then a second init pulse that must be ignored.
    while (cyc < 215) applyStimulus(CMD_IDLE, (cyc == 205), "init_window");

    // Remaining timed states and back-to-back switches.
    holdState(CMD_PRECHARGE, 6, "precharge");
    holdState(CMD_REFRESH, 34, "refresh");
    holdState(CMD_ACTIVATE, 2, "act_short");
    holdState(CMD_WRITE, 10, "act_to_write");
    holdState(CMD_PRECHARGE, 1, "pre_short");
    holdState(CMD_READ, 9, "pre_to_read");
    holdState(CMD_MRS, 3, "untimed_mrs");
    holdState(CMD_INIT, 2, "untimed_init");

    // Randomized command segments with occasional init pulses.
    for (int s = 0; s < 100; s++) begin
      cmd_fsm_t c;
      int       len;
      c   = cmd_fsm_t'($urandom_range(0, 7));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) applyStimulus(c, ($urandom_range(0, 15) == 0), "random");
    end

    // Long idle stretch: refresh request, then overflow when enabled; nothing otherwise.
    holdState(CMD_IDLE, 3300, "refresh_idle");
    holdState(CMD_REFRESH, 36, "refresh_service");
    holdState(CMD_IDLE, 10, "post_refresh");

    // Asynchronous reset in the middle of a WRITE interval.
    holdState(CMD_WRITE, 3, "write_before_reset");
    cmd_state = CMD_WRITE;
    #2;
    RST = 1'b1;
    #1;
    checkAllLow("async_reset");
    modelReset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // After reset: timing works, but refresh stays quiet until a new init.
    holdState(CMD_WRITE, 12, "write_after_reset");
    holdState(CMD_REFRESH, 40, "refresh_no_init");
    holdState(CMD_IDLE, 1700, "idle_no_init");
    applyStimulus(CMD_IDLE, 1'b1, "reinit_pulse");
    holdState(CMD_IDLE, 210, "reinit_wait");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_timing_ctrl.md
DRAM_TIMING_CTRL -- requirements
Module: dram_timing_ctrl

Interface
REQ-001 SHALL have parameters: tINIT 16'd200, power-up init cycles; tRCD 16'd4, ACT-to-RD/WR cycles; tRD 16'd8, read burst cycles (CL + burst); tWR 16'd8, write burst + write recovery cycles; tRP 16'd4, precharge cycles; tRFC 16'd32, refresh cycles; tREFI 16'd1560, refresh interval cycles.
REQ-002 SHALL have ports, name direction width meaning, one per line:
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 cmd_state  input  cmd_fsm_t (dram_pack)  current command FSM state.
REQ-006 init_req  input  1  command FSM requests power-up init timing.
REQ-007 init_done  output  1  init interval complete, sticky.
REQ-008 tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done  output  1 each  timing interval of the current state elapsed.
REQ-009 rf_req  output  1  refresh due, held until serviced.
REQ-010 rf_overflow  output  1  sticky: a second tREFI elapsed while rf_req still pending.

Function
REQ-011 Timed states SHALL be ACTIVATE->tRCD/tACT_done, READ->tRD/tRD_done, WRITE->tWR/tWR_done, PRECHARGE->tRP/tPRE_done, REFRESH->tRFC/tREF_done; every other cmd_state value SHALL be untimed.
REQ-012 Block SHALL register cmd_state as prev_state each cycle; entry cycle = cmd_state is timed and differs from prev_state.
REQ-013 On entry cycle a 16-bit down-counter SHALL load T-1 (T = state's parameter); each later cycle in the same state it SHALL decrement, saturating at 0.
REQ-014 The state's done output SHALL be high when counter == 0, cmd_state unchanged, and not an entry cycle; first asserted exactly T cycles after the entry cycle; held while state persists.
REQ-015 At most one of the five done outputs SHALL be high in any cycle; all SHALL be low in untimed states.
REQ-016 Leaving a timed state before done SHALL abandon the count; entering another timed state SHALL reload from that state's parameter (direct state-to-state switch counts as entry).
REQ-017 Parameters SHALL be >= 1; T = 1 gives done on cycle after entry.
REQ-018 Init: rising init_req while init_done low SHALL start a tINIT counter; init_done SHALL set tINIT cycles after the start cycle and stay high until reset; init_req while init_done high SHALL be ignored; dropping init_req mid-count SHALL not stop it.
REQ-019 Refresh (when compiled in): free-running interval counter SHALL start after init_done sets, count 0..tREFI-1 and wrap; at wrap rf_req SHALL set.
REQ-020 rf_req SHALL clear on the REFRESH entry cycle; interval counter SHALL restart from 0 on that same cycle.
REQ-021 Wrap coinciding with REFRESH entry: entry wins, rf_req clears, no overflow.
REQ-022 Wrap while rf_req already high SHALL set rf_overflow; rf_req stays high.

Reset
REQ-023 RST high SHALL asynchronously clear prev_state to untimed, all counters to 0, init_done, rf_req, rf_overflow and all done outputs to 0.
REQ-024 Reset mid-interval SHALL abandon the interval; after release the block SHALL need a new init_req before refresh counting resumes.

Configuration
REQ-025 Macro DRAM_AUTO_REFRESH_EN SHALL control refresh generation.
REQ-026 Defined: REQ-019..022 apply. Undefined: interval counter absent, rf_req and rf_overflow tied 0; tREF_done timing still functional.

Verification
REQ-027 RST pulse mid-WRITE count -> all outputs 0 immediately, asynchronously.
REQ-028 init_req pulse at cycle 0, tINIT=200 -> init_done high from cycle 200, stays high; second init_req no effect.
REQ-029 cmd_state ACTIVATE entered cycle 10, tRCD=4 -> tACT_done high cycle 14 onward; switch to READ cycle 16 -> tACT_done low, tRD_done high cycle 24.
REQ-030 WRITE entered then left after 3 cycles (tWR=8) and re-entered -> tWR_done only 8 cycles after re-entry.
REQ-031 DRAM_AUTO_REFRESH_EN, tREFI=1560, no REFRESH -> rf_req at 1560 cycles after init_done, rf_overflow after 3120; REFRESH entry -> rf_req low next cycle, tREF_done after tRFC=32.
REQ-032 Macro undefined -> rf_req, rf_overflow 0 over 5000 cycles; REFRESH state still yields tREF_done after 32 cycles.
